// File: rtl/z_seq_checker_if.sv
// rtl/z_seq_checker_if.sv - Z symbol stream bundle from the sequence generator to the checker
interface z_seq_checker_if;
    logic       valid_in;
    logic [1:0] sel_in;
    logic [1:0] z_in;

    modport master (output valid_in, output sel_in, output z_in);
    modport slave  (input  valid_in, input  sel_in, input  z_in);
endinterface

// File: rtl/z_seq_checker.sv
// rtl/z_seq_checker.sv - Z symbol stream pattern checker with frame and mismatch counters
module z_seq_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    z_seq_checker_if.slave   zs,
    output logic             locked,
    output logic             frame_done,
    output logic             err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       cur_sel
);

    typedef enum logic {HUNT = 1'b0, TRACK = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_n;
    logic [3:0]       phase, phase_n;
    logic [1:0]       sel_n;
    logic             done_n, err_n;
    logic [CNT_W-1:0] fcnt_n, ecnt_n;
    logic [1:0]       eff_sel;
    logic             sym_ok;

    // Symbol expected at position idx of pattern sel; out-of-range positions never match
    function automatic logic [2:0] pat_sym(input logic [1:0] sel, input logic [3:0] idx);
        logic [2:0] r;
        r = 3'b100;
        case (sel)
            2'd0: case (idx)
                4'd0: r = 3'd3;  4'd1: r = 3'd2;  4'd2: r = 3'd0;  4'd3: r = 3'd3;
                4'd4: r = 3'd3;  4'd5: r = 3'd0;  4'd6: r = 3'd2;  4'd7: r = 3'd3;
                4'd8: r = 3'd1;  4'd9: r = 3'd2;  4'd10: r = 3'd2; 4'd11: r = 3'd1;
                default: r = 3'b100;
            endcase
            2'd1: case (idx)
                4'd0: r = 3'd1;  4'd1: r = 3'd3;  4'd2: r = 3'd2;  4'd3: r = 3'd0;
                default: r = 3'b100;
            endcase
            2'd2: case (idx)
                4'd0: r = 3'd2;  4'd1: r = 3'd1;  4'd2: r = 3'd2;  4'd3: r = 3'd2;
                4'd4: r = 3'd3;  4'd5: r = 3'd0;
                default: r = 3'b100;
            endcase
            default: case (idx)
                4'd0: r = 3'd1;  4'd1: r = 3'd2;
                default: r = 3'b100;
            endcase
        endcase
        return r;
    endfunction

    // Index of the last symbol of each pattern
    function automatic logic [3:0] last_idx(input logic [1:0] sel);
        case (sel)
            2'd0:    return 4'd11;
            2'd1:    return 4'd3;
            2'd2:    return 4'd5;
            default: return 4'd1;
        endcase
    endfunction

    // Next-state logic: hunt for the pattern start, then walk the pattern phase by phase
    always_comb begin
        state_n = state;
        phase_n = phase;
        sel_n   = cur_sel;
        done_n  = 1'b0;
        err_n   = 1'b0;
        fcnt_n  = frame_cnt;
        ecnt_n  = err_cnt;
        eff_sel = cur_sel;
        sym_ok  = 1'b0;
        if (zs.valid_in) begin
            // The selector only takes effect at a frame boundary
            if (state == HUNT || phase == 4'd0) begin
                eff_sel = zs.sel_in;
                sel_n   = zs.sel_in;
            end
            sym_ok = (pat_sym(eff_sel, (state == HUNT) ? 4'd0 : phase) == {1'b0, zs.z_in});
            if (state == HUNT) begin
                if (sym_ok) begin
                    state_n = TRACK;
                    phase_n = 4'd1;
                end else begin
                    phase_n = 4'd0;
                end
            end else if (sym_ok) begin
                if (phase == last_idx(eff_sel)) begin
                    phase_n = 4'd0;
                    done_n  = 1'b1;
                    if (frame_cnt != '1) fcnt_n = frame_cnt + CNT_ONE;
                end else begin
                    phase_n = phase + 4'd1;
                end
            end else begin
                // The offending symbol is not reused as a hunt candidate
                state_n = HUNT;
                phase_n = 4'd0;
                err_n   = 1'b1;
                if (err_cnt != '1) ecnt_n = err_cnt + CNT_ONE;
            end
        end
    end

    // State, position and status registers; everything is visible one cycle after the sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            phase      <= 4'd0;
            cur_sel    <= 2'd0;
            locked     <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            cur_sel    <= sel_n;
            locked     <= (state_n == TRACK);
            frame_done <= done_n;
            err        <= err_n;
            frame_cnt  <= fcnt_n;
            err_cnt    <= ecnt_n;
        end
    end

endmodule

// File: doc/z_seq_checker.md
Name: z_seq_checker

Overview:
- Downstream consumer of the 2-bit Z symbol stream produced by the selectable-pattern sequence generator.
- Each cycle it compares the incoming symbol against the expected pattern for the selector value, tracks frame position, and reports frame completions and mismatches.
- Provides self-checking and status for the generator stage on the same clock.

Parameters:
- CNT_W, 8, width of the frame and error counters (saturating).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid_in  input  1  z_in/sel_in are sampled this cycle when high.
- sel_in  input  2  pattern selector driving the generator.
- z_in  input  2  symbol from the generator.
- locked  output  1  high while in TRACK.
- frame_done  output  1  one-cycle pulse; last symbol of a frame matched.
- err  output  1  one-cycle pulse; mismatch while in TRACK.
- frame_cnt  output  CNT_W  completed frames, saturates at all-ones.
- err_cnt  output  CNT_W  mismatches, saturates at all-ones.
- cur_sel  output  2  selector latched for the current frame.

Behaviour:
- Pattern table, index 0 first:
  - sel 0, length 12: 3,2,0,3,3,0,2,3,1,2,2,1
  - sel 1, length 4: 1,3,2,0
  - sel 2, length 6: 2,1,2,2,3,0
  - sel 3, length 2: 1,2
- Internal state:
  - 4-bit phase register.
  - 2-bit latched selector.
  - FSM with states HUNT and TRACK.
- Reset (asynchronous, rst_n low), effective immediately and independent of clk:
  - FSM goes to HUNT; phase=0; cur_sel=0.
  - locked=0, frame_done=0, err=0, frame_cnt=0, err_cnt=0.
- valid_in low: no state change; frame_done and err are 0 on the next edge.
- HUNT, on a valid sample:
  - Latch sel_in into cur_sel.
  - If z_in == pattern[sel_in][0]: go to TRACK, phase=1.
  - If the pattern length is 2 and the symbol matched, phase=1 still applies; the frame completes on the next match.
  - Otherwise stay in HUNT, phase=0.
  - No err is raised in HUNT.
- TRACK, on a valid sample, compare z_in with pattern[cur_sel][phase]; sel_in is ignored except when phase==0.
  - Match, phase < length-1: phase increments.
  - Match, phase == length-1: phase=0, frame_done=1, frame_cnt increments (saturating).
  - Match at phase==0: cur_sel is re-latched from sel_in before the compare, so the selector changes only on frame boundaries.
  - Mismatch: err=1, err_cnt increments (saturating), FSM goes to HUNT with phase=0. The same symbol is NOT re-used for hunting; the next valid sample starts the hunt.
- locked is the registered equivalent of state==TRACK and is updated on the same edge as the transition.
- Latency: all outputs are registered and reflect the sample taken at edge N on the cycle after edge N (one-cycle latency).
- Boundaries:
  - Counter saturation holds at 2^CNT_W-1; no wrap.
  - frame_done and err are never both high in the same cycle.
  - A sel_in change mid-frame has no effect until the next phase==0 valid sample.
  - Gaps in valid_in are allowed anywhere without loss of position.
  - A reset asserted mid-frame discards the partial frame.
- Unused phase values (phase >= length) are unreachable. If reached, they are treated as a mismatch.

Test Plan:
- Reset then sel_in=1, valid_in=1, z_in=1,3,2,0 repeated 3 frames -> locked=1 after first sample; frame_done pulses 3 times; frame_cnt=3; err_cnt=0.
- sel_in=0, feed the full 12-symbol sequence but change symbol 5 (value 3) to 1 -> err pulse one cycle after symbol 5; err_cnt=1; locked=0; next 3 (sel 0 start) relocks.
- sel_in=3, feed 1,2 with valid_in low for 3 cycles between the symbols -> frame_done=1 once; phase position retained across the gap; no err.
- sel_in=2 frame in progress; switch sel_in to 1 at phase 3; complete 2,3,0 -> frame_done at end, cur_sel=2; next frame cur_sel=1.
- CNT_W=2, 5 complete sel 3 frames -> frame_cnt saturates at 3.
- Assert rst_n low mid-frame (sel 0, phase 7) asynchronously between clock edges -> all outputs 0 immediately; after release, a fresh 12-symbol frame gives frame_cnt=1.
